// File: rtl/divide_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divide_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/divide_step.sv
// One combinational restoring shift-subtract step of the divider.
module divide_step
  import divide_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] remainder,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_remainder,
  output logic             quotient_bit
);

  logic [WIDTH:0] trial;

  // remainder < divisor always holds, so the WIDTH+1 bit difference is
  // either in [0, divisor) or wraps with its top bit set; that bit is the borrow.
  assign trial          = {remainder, dividend_bit} - {1'b0, divisor};
  assign quotient_bit   = ~trial[WIDTH];
  assign next_remainder = quotient_bit ? trial[WIDTH-1:0]
                                       : {remainder[WIDTH-2:0], dividend_bit};

endmodule

// File: rtl/divide.sv
// Multi-cycle restoring divider: WIDTH steps, one per clock.
// Signed operation is compiled in only when DIVIDE_SIGNED_EN is defined.
module divide
  import divide_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] divisor, dividend, rem;
  logic [WIDTH-1:0] step_rem, quot;
  logic             step_q;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef DIVIDE_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  assign a_neg = is_signed & A[WIDTH-1];
  assign b_neg = is_signed & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag            = A;
  assign b_mag            = B;
`endif

  divide_step #(.WIDTH(WIDTH)) u_step (
    .remainder     (rem),
    .dividend_bit  (dividend[WIDTH-1]),
    .divisor       (divisor),
    .next_remainder(step_rem),
    .quotient_bit  (step_q)
  );

  // Quotient bits shift into the dividend register as its bits are consumed.
  assign quot = {dividend[WIDTH-2:0], step_q};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (B == '0) ? DONE : RUN;
      RUN:     if (count == CW'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      divisor  <= '0;
      dividend <= '0;
      rem      <= '0;
      Hi       <= '0;
      Lo       <= '0;
`ifdef DIVIDE_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count    <= CW'(WIDTH);
            divisor  <= b_mag;
            dividend <= a_mag;
            rem      <= '0;
`ifdef DIVIDE_SIGNED_EN
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
`endif
            // Divide by zero bypasses RUN and reports the raw dividend.
            if (B == '0) begin
              Hi <= A;
              Lo <= '1;
            end
          end
        end
        RUN: begin
          count    <= count - CW'(1);
          rem      <= step_rem;
          dividend <= quot;
          if (count == CW'(1)) begin
`ifdef DIVIDE_SIGNED_EN
            Lo <= neg_q ? -quot : quot;
            Hi <= neg_r ? -step_rem : step_rem;
`else
            Lo <= quot;
            Hi <= step_rem;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide.sv
// Randomized and directed self-checking bench for the divider against an arithmetic model.
module tb_divide;

`ifdef DIVIDE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] Hi, Lo;

  int checks   = 0;
  int failures = 0;

  divide dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Quotient truncates toward zero, remainder follows the dividend's sign.
  function automatic void refDivide(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && SIGNED_EN) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] expQ, expR, prevHi, prevLo;
    int          cyc;
    bit          moved;
    refDivide(a, b, s, expQ, expR);
    @(negedge clock);
    A = a; B = b; is_signed = s; start = 1'b1;
    prevHi = Hi; prevLo = Lo;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1; moved = 1'b0;
    while (done !== 1'b1 && cyc < 100) begin
      if (Hi !== prevHi || Lo !== prevLo) moved = 1'b1;
      @(posedge clock);
      #1 cyc++;
    end
    checkOutput({tag, " latency"}, 32'(cyc), (b == 32'd0) ? 32'd1 : 32'd33);
    checkOutput({tag, " hold"}, 32'(moved), 32'd0);
    checkOutput({tag, " Lo"}, Lo, expQ);
    checkOutput({tag, " Hi"}, Hi, expR);
    @(posedge clock);
    #1;
    checkOutput({tag, " busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, " done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          cyc, doneCount;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset Hi", Hi, 32'd0);
    checkOutput("reset Lo", Lo, 32'd0);
    @(negedge clock) reset = 1'b0;

    applyStimulus("100/7", 32'd100, 32'd7, 1'b0);
    applyStimulus("5/0", 32'd5, 32'd0, 1'b0);
    applyStimulus("neg7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    applyStimulus("minint/neg1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    applyStimulus("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    applyStimulus("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("big/big", 32'hFFFF_FFFE, 32'h8000_0001, 1'b0);
    applyStimulus("neg/0", 32'hFFFF_FFF9, 32'd0, 1'b1);

    // Abort mid-run with reset, then confirm a fresh division works.
    @(negedge clock);
    A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    doneCount = 0;
    repeat (9) begin
      @(posedge clock);
      #1 if (done === 1'b1) doneCount++;
    end
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort Hi", Hi, 32'd0);
    checkOutput("abort Lo", Lo, 32'd0);
    @(negedge clock) reset = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1 if (done === 1'b1) doneCount++;
    end
    checkOutput("abort no_done", 32'(doneCount), 32'd0);
    applyStimulus("9/3", 32'd9, 32'd3, 1'b0);

    // Starts during RUN and during the DONE cycle must be dropped.
    @(negedge clock);
    A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin
        A = 32'd50; B = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1 cyc++;
    end
    checkOutput("ignore latency", 32'(cyc), 32'd33);
    A = 32'd60; B = 32'd6; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    checkOutput("ignore busy", 32'(busy), 32'd0);
    doneCount = 0;
    repeat (40) begin
      @(posedge clock);
      #1 if (done === 1'b1) doneCount++;
    end
    checkOutput("ignore extra_done", 32'(doneCount), 32'd0);
    checkOutput("ignore Lo", Lo, 32'd14);
    checkOutput("ignore Hi", Hi, 32'd2);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = (i % 8 == 7) ? 32'd0 : ~32'($urandom_range(0, 15));
      endcase
      applyStimulus($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
